// File: rtl/ymn_sms_pkg.sv
// Shared constants and helpers for the YMN clock/phase generator family.
// Default divider settings live here so every block that depends on the
// phase timing agrees on them.
package ymn_sms_pkg;

  // Master clocks per phase cycle (even, at least 4).
  localparam int DEF_DIV      = 4;

  // Phase cycles per PSG tick (at least 2).
  localparam int DEF_PSG_DIV  = 16;

  // Phase cycles the downstream chip reset stays asserted after release.
  localparam int DEF_RST_HOLD = 2;

  // Number of bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ymn_clk_phase_gen_if.sv
// Control and timing-output bundle of the clock/phase generator.
// The master side owns the enables; the slave side (the generator) drives
// the phase pulses, phase position, PSG tick and stretched chip reset.
interface ymn_clk_phase_gen_if
  import ymn_sms_pkg::*;
#(
  parameter int DIV = DEF_DIV
);

  logic                    clk_en;
  logic                    resync;
  logic                    c1;
  logic                    c2;
  logic [$clog2(DIV)-1:0]  phase;
  logic                    psg_tick;
  logic                    ic_reset;

  // Controller driving the generator.
  modport master (
    output clk_en,
    output resync,
    input  c1,
    input  c2,
    input  phase,
    input  psg_tick,
    input  ic_reset
  );

  // The generator itself.
  modport slave (
    input  clk_en,
    input  resync,
    output c1,
    output c2,
    output phase,
    output psg_tick,
    output ic_reset
  );

endinterface

// File: rtl/ymn_mod_cnt.sv
// Modulo-MOD counter with advance enable, synchronous load and a wrap flag.
// The value the counter is about to take is exported so the parent can
// register its outputs from the new position in the same edge.
module ymn_mod_cnt
  import ymn_sms_pkg::*;
#(
  parameter int MOD     = 4,
  parameter int W       = cntWidth(MOD),
  parameter int RST_VAL = MOD - 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_nxt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next value: hold when disabled, load takes priority over counting, and
  // the count rolls from MOD-1 back to zero.  Entering zero counts as a wrap,
  // whether it came from rolling over or from a load of zero.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (en_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (cnt_q == W'(MOD - 1)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      wrap_o = (cnt_d == '0);
    end
    cnt_nxt_o = cnt_d;
  end

  // Count register; reset parks the counter one step before zero so the
  // first enabled edge after release lands on zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ymn_clk_phase_gen.sv
// Two-phase non-overlapping clock-enable generator.
// A phase counter walks 0..DIV-1 on every enabled MCLK edge; c1 occupies the
// first half of the cycle minus a guard slot and c2 the second half minus a
// guard slot, so the two enables are always separated by an idle MCLK.
// A second counter divides phase cycles down to the PSG tick, and a small
// saturating counter stretches the chip reset for RST_HOLD phase cycles.
module ymn_clk_phase_gen
  import ymn_sms_pkg::*;
#(
  parameter int DIV      = DEF_DIV,
  parameter int PSG_DIV  = DEF_PSG_DIV,
  parameter int RST_HOLD = DEF_RST_HOLD
) (
  input  logic                MCLK,
  input  logic                reset,
  ymn_clk_phase_gen_if.slave  bus
);

  localparam int PW  = $clog2(DIV);
  localparam int PSW = cntWidth(PSG_DIV);
  localparam int HW  = cntWidth(RST_HOLD + 1);

  logic [PW-1:0]  cntNew;
  logic           phaseWrap;
  logic [PSW-1:0] unusedPsgNext;
  logic           psgWrap;

  logic           c1_q, c1_d;
  logic           c2_q, c2_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic           psgTick_q, psgTick_d;
  logic [HW-1:0]  holdCnt_q, holdCnt_d;
  logic           icReset_q, icReset_d;

  // Position within the phase cycle; resync forces a jump to slot zero.
  ymn_mod_cnt #(
    .MOD     (DIV),
    .W       (PW),
    .RST_VAL (DIV - 1)
  ) uPhaseCnt (
    .clk_i      (MCLK),
    .rst_i      (reset),
    .en_i       (bus.clk_en),
    .load_i     (bus.resync),
    .load_val_i ('0),
    .cnt_nxt_o  (cntNew),
    .wrap_o     (phaseWrap)
  );

  // Phase-cycle divider for the PSG; it steps once per phase wrap.
  ymn_mod_cnt #(
    .MOD     (PSG_DIV),
    .W       (PSW),
    .RST_VAL (PSG_DIV - 1)
  ) uPsgCnt (
    .clk_i      (MCLK),
    .rst_i      (reset),
    .en_i       (phaseWrap),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_nxt_o  (unusedPsgNext),
    .wrap_o     (psgWrap)
  );

  // Output decode from the new phase position, gated by the enable, plus the
  // reset-stretch bookkeeping; chip reset drops on the wrap that starts phase
  // cycle RST_HOLD and then stays low until the next hard reset.
  always_comb begin
    c1_d      = bus.clk_en && (cntNew < PW'(DIV / 2 - 1));
    c2_d      = bus.clk_en && (cntNew >= PW'(DIV / 2)) && (cntNew <= PW'(DIV - 2));
    phase_d   = cntNew;
    psgTick_d = psgWrap;
    holdCnt_d = holdCnt_q;
    if (phaseWrap && (holdCnt_q < HW'(RST_HOLD))) begin
      holdCnt_d = holdCnt_q + 1'b1;
    end
    icReset_d = icReset_q && !(phaseWrap && (holdCnt_q == HW'(RST_HOLD)));
  end

  // Output and reset-stretch registers.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      c1_q      <= 1'b0;
      c2_q      <= 1'b0;
      phase_q   <= PW'(DIV - 1);
      psgTick_q <= 1'b0;
      holdCnt_q <= '0;
      icReset_q <= 1'b1;
    end else begin
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      phase_q   <= phase_d;
      psgTick_q <= psgTick_d;
      holdCnt_q <= holdCnt_d;
      icReset_q <= icReset_d;
    end
  end

  assign bus.c1       = c1_q;
  assign bus.c2       = c2_q;
  assign bus.phase    = phase_q;
  assign bus.psg_tick = psgTick_q;
  assign bus.ic_reset = icReset_q;

endmodule

// File: tb/tb_ymn_clk_phase_gen.sv
// Scoreboard bench for the clock/phase generator.
// The driver sets inputs on the falling edge, advances a reference model
// that reasons in phase slots and phase-cycle indices, and queues the outputs
// expected after the next rising edge.  The monitor pops one expectation per
// rising edge and compares it against the interface.
module tb_ymn_clk_phase_gen;

  localparam int DIV      = 4;
  localparam int PSG_DIV  = 16;
  localparam int RST_HOLD = 2;
  localparam int PW       = $clog2(DIV);

  typedef struct {
    logic          c1;
    logic          c2;
    logic [PW-1:0] phase;
    logic          psgTick;
    logic          icReset;
  } expT;

  logic MCLK;
  logic reset;

  ymn_clk_phase_gen_if #(.DIV(DIV)) bus ();

  ymn_clk_phase_gen #(
    .DIV      (DIV),
    .PSG_DIV  (PSG_DIV),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .MCLK  (MCLK),
    .reset (reset),
    .bus   (bus)
  );

  expT expQ[$];
  int  assertCount = 0;
  int  failCount   = 0;
  int  monCycle    = 0;

  int  mPos = DIV - 1;
  int  mCyc = -1;

  // Free-running master clock.
  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // One comparison: count it and report a mismatch.
  task automatic checkField(input string name, input int got, input int want);
    assertCount++;
    if (got != want) begin
      failCount++;
      $display("[TB] FAIL %s at monitor cycle %0d: got %0d expected %0d", name, monCycle, got, want);
    end
  endtask

  // Compare every output against one queued expectation.
  task automatic checkOutput(input expT e);
    checkField("c1", int'(bus.c1), int'(e.c1));
    checkField("c2", int'(bus.c2), int'(e.c2));
    checkField("phase", int'(bus.phase), int'(e.phase));
    checkField("psg_tick", int'(bus.psg_tick), int'(e.psgTick));
    checkField("ic_reset", int'(bus.ic_reset), int'(e.icReset));
    checkField("c1_c2_overlap", int'(bus.c1 & bus.c2), 0);
  endtask

  // Drive one cycle of inputs and queue what the next rising edge should show.
  // Reference: slot position mPos, and mCyc = index of the current phase cycle
  // since reset (-1 before the first one starts).
  task automatic applyStimulus(input logic rst, input logic en, input logic rs);
    expT e;
    @(negedge MCLK);
    reset      = rst;
    bus.clk_en = en;
    bus.resync = rs;
    if (rst) begin
      mPos      = DIV - 1;
      mCyc      = -1;
      e.c1      = 1'b0;
      e.c2      = 1'b0;
      e.phase   = PW'(DIV - 1);
      e.psgTick = 1'b0;
      e.icReset = 1'b1;
    end else if (en) begin
      mPos      = rs ? 0 : (mPos + 1) % DIV;
      if (mPos == 0) mCyc++;
      e.c1      = (mPos < DIV / 2 - 1);
      e.c2      = (mPos >= DIV / 2) && (mPos <= DIV - 2);
      e.phase   = PW'(mPos);
      e.psgTick = (mPos == 0) && ((mCyc % PSG_DIV) == 0);
      e.icReset = !(mCyc >= RST_HOLD);
    end else begin
      e.c1      = 1'b0;
      e.c2      = 1'b0;
      e.phase   = PW'(mPos);
      e.psgTick = 1'b0;
      e.icReset = !(mCyc >= RST_HOLD);
    end
    expQ.push_back(e);
  endtask

  // Run enabled cycles until the model sits at the requested slot.
  task automatic runToPhase(input int target);
    for (int i = 0; i < DIV && mPos != target; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
  endtask

  // Monitor: one expectation consumed per rising edge, sampled just after it.
  initial begin
    forever begin
      @(posedge MCLK);
      #1;
      if (expQ.size() > 0) begin
        monCycle++;
        checkOutput(expQ.pop_front());
      end
    end
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    reset      = 1'b1;
    bus.clk_en = 1'b0;
    bus.resync = 1'b0;

    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (140) applyStimulus(1'b0, 1'b1, 1'b0);

    runToPhase(1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);

    runToPhase(2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    runToPhase(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

    runToPhase(2);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(3) != 0), ($urandom_range(7) == 0));
    end
    applyStimulus(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge MCLK);
    #2;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
